// File: rtl/out_nibble_arbiter.sv
// Round-robin arbiter for four nibble requesters sharing one 4-bit output.
// Ports: CLK, RST (async high), REQ[3:0], DIN[15:0] in; ACK, O, STB, BUSY, GNT_ID out.
module out_nibble_arbiter #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [15:0] DIN,
  output logic [3:0]  ACK,
  output logic [3:0]  O,
  output logic        STB,
  output logic        BUSY,
  output logic [1:0]  GNT_ID
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  o_d, ack_d;
  logic        stb_d, busy_d;
  logic [1:0]  gnt_d;

  logic [2:0]  rot_sh;
  logic [3:0]  rot;
  logic [1:0]  off;
  logic [1:0]  win;
  logic [3:0]  win_nib;

  // Rotate REQ so the requester after LAST lands in bit 0,
  // then the lowest set bit is the round-robin winner.
  always_comb begin
    rot_sh = {1'b0, last_q} + 3'd1;
    rot    = 4'({REQ, REQ} >> rot_sh);
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    win = last_q + 2'd1 + off;
  end

  always_comb begin
    unique case (win)
      2'd0: win_nib = DIN[3:0];
      2'd1: win_nib = DIN[7:4];
      2'd2: win_nib = DIN[11:8];
      2'd3: win_nib = DIN[15:12];
      default: win_nib = DIN[3:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    o_d     = O;
    gnt_d   = GNT_ID;
    ack_d   = 4'd0;
    stb_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = HOLD;
          last_d  = win;
          cnt_d   = 4'(HOLD_CYCLES - 1);
          o_d     = win_nib;
          gnt_d   = win;
          ack_d   = 4'b0001 << win;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      O       <= 4'd0;
      GNT_ID  <= 2'd0;
      ACK     <= 4'd0;
      STB     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      O       <= o_d;
      GNT_ID  <= gnt_d;
      ACK     <= ack_d;
      STB     <= stb_d;
      BUSY    <= busy_d;
    end
  end

endmodule

// File: tb/tb_out_nibble_arbiter.sv
// Bench for out_nibble_arbiter: three instances (HOLD_CYCLES 2, 4, 1)
// checked every cycle against a queue-free behavioural model plus literals.
module tb_out_nibble_arbiter;

  localparam int H [3] = '{2, 4, 1};

  logic        clk;
  logic        rst [3];
  logic [3:0]  req [3];
  logic [15:0] din [3];
  logic [3:0]  ack [3];
  logic [3:0]  o   [3];
  logic        stb [3];
  logic        busy[3];
  logic [1:0]  gid [3];

  int n_chk  = 0;
  int n_fail = 0;

  out_nibble_arbiter #(.HOLD_CYCLES(2)) u0 (
    .CLK(clk), .RST(rst[0]), .REQ(req[0]), .DIN(din[0]),
    .ACK(ack[0]), .O(o[0]), .STB(stb[0]), .BUSY(busy[0]), .GNT_ID(gid[0]));
  out_nibble_arbiter #(.HOLD_CYCLES(4)) u1 (
    .CLK(clk), .RST(rst[1]), .REQ(req[1]), .DIN(din[1]),
    .ACK(ack[1]), .O(o[1]), .STB(stb[1]), .BUSY(busy[1]), .GNT_ID(gid[1]));
  out_nibble_arbiter #(.HOLD_CYCLES(1)) u2 (
    .CLK(clk), .RST(rst[2]), .REQ(req[2]), .DIN(din[2]),
    .ACK(ack[2]), .O(o[2]), .STB(stb[2]), .BUSY(busy[2]), .GNT_ID(gid[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hold_left counts HOLD cycles still to run; winner is the
  // first requester found scanning LAST+1 .. LAST+4 (mod 4).
  int         hold_left [3] = '{0, 0, 0};
  int         m_last    [3] = '{3, 3, 3};
  logic [3:0] m_o   [3];
  logic [3:0] m_ack [3];
  logic       m_stb [3];
  logic       m_busy[3];
  logic [1:0] m_gid [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_o[d] = 0; m_ack[d] = 0; m_stb[d] = 0; m_busy[d] = 0; m_gid[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int w;
      w = -1;
      if (rst[d]) begin
        hold_left[d] = 0; m_last[d] = 3;
        m_o[d] = 0; m_ack[d] = 0; m_stb[d] = 0; m_busy[d] = 0; m_gid[d] = 0;
      end else if (hold_left[d] > 0) begin
        hold_left[d]--;
        m_ack[d]  = 0;
        m_stb[d]  = 0;
        m_busy[d] = (hold_left[d] > 0);
      end else if (req[d] != 0) begin
        for (int k = 1; k <= 4; k++)
          if (w < 0 && req[d][(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
        hold_left[d] = H[d];
        m_last[d] = w;
        m_o[d]    = din[d][4*w +: 4];
        m_gid[d]  = 2'(w);
        m_ack[d]  = 4'(1 << w);
        m_stb[d]  = 1;
        m_busy[d] = 1;
      end else begin
        m_ack[d] = 0; m_stb[d] = 0; m_busy[d] = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_ack%0d", d), int'(ack[d]), int'(m_ack[d]));
      chk($sformatf("model_o%0d", d), int'(o[d]), int'(m_o[d]));
      chk($sformatf("model_stb%0d", d), int'(stb[d]), int'(m_stb[d]));
      chk($sformatf("model_busy%0d", d), int'(busy[d]), int'(m_busy[d]));
      chk($sformatf("model_gid%0d", d), int'(gid[d]), int'(m_gid[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1; req[d] = 0; din[d] = 0;
    end
    repeat (2) tick();

    // reset with all requesting
    req[0] = 4'hF; din[0] = 16'h4321;
    tick();
    chk("rst_ack", int'(ack[0]), 0);
    chk("rst_o", int'(o[0]), 0);
    chk("rst_stb", int'(stb[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_gid", int'(gid[0]), 0);
    for (int d = 0; d < 3; d++) rst[d] = 0;
    tick();
    chk("first_ack", int'(ack[0]), 1);
    chk("first_gid", int'(gid[0]), 0);
    chk("first_stb", int'(stb[0]), 1);
    chk("first_o", int'(o[0]), 1);
    req[0] = 0;
    tick();
    chk("first_busy2", int'(busy[0]), 1);
    tick();
    chk("first_idle", int'(busy[0]), 0);

    // single request, other nibbles are noise
    req[0] = 4'b0100; din[0] = 16'hFAFF;
    tick();
    chk("single_o", int'(o[0]), 'hA);
    chk("single_ack", int'(ack[0]), 4'b0100);
    chk("single_stb", int'(stb[0]), 1);
    chk("single_busy1", int'(busy[0]), 1);
    req[0] = 0;
    tick();
    chk("single_busy2", int'(busy[0]), 1);
    chk("single_stb2", int'(stb[0]), 0);
    tick();
    chk("single_busy3", int'(busy[0]), 0);
    chk("single_o_keep", int'(o[0]), 'hA);
    tick();
    chk("single_o_keep2", int'(o[0]), 'hA);

    // fairness from a fresh reset
    rst[0] = 1;
    tick();
    rst[0] = 0; req[0] = 4'hF; din[0] = 16'h7654;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i % 3 == 0) begin
        chk("rr_ack", int'(ack[0]), 1 << ((i / 3) % 4));
        chk("rr_gid", int'(gid[0]), (i / 3) % 4);
      end else begin
        chk("rr_gap", int'(ack[0]), 0);
      end
    end
    req[0] = 0;
    repeat (2) tick();

    // ignore requests raised in HOLD
    req[0] = 4'b0010;
    tick();
    chk("ign_ack1", int'(ack[0]), 4'b0010);
    req[0] = 4'b0001;
    tick();
    chk("ign_hold", int'(ack[0]), 0);
    tick();
    chk("ign_idle", int'(ack[0]), 0);
    tick();
    chk("ign_ack0", int'(ack[0]), 4'b0001);
    req[0] = 0;
    repeat (2) tick();

    // mid-HOLD reset on the HOLD_CYCLES=4 instance
    req[1] = 4'b0100; din[1] = 16'h0B00;
    tick();
    chk("mr_ack", int'(ack[1]), 4'b0100);
    chk("mr_o", int'(o[1]), 'hB);
    req[1] = 0;
    tick();
    chk("mr_busy", int'(busy[1]), 1);
    rst[1] = 1;
    #1;
    chk("mr_async_o", int'(o[1]), 0);
    chk("mr_async_busy", int'(busy[1]), 0);
    chk("mr_async_gid", int'(gid[1]), 0);
    tick();
    rst[1] = 0; req[1] = 4'b0100;
    tick();
    chk("mr_regrant_ack", int'(ack[1]), 4'b0100);
    chk("mr_regrant_stb", int'(stb[1]), 1);
    req[1] = 0;
    repeat (5) tick();
    chk("mr_done_busy", int'(busy[1]), 0);

    // HOLD_CYCLES=1 alternation
    req[2] = 4'b1010; din[2] = 16'h9050;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("h1_ack", int'(ack[2]), ((i / 2) % 2 == 0) ? 4'b0010 : 4'b1000);
        chk("h1_stb", int'(stb[2]), 1);
        chk("h1_busy", int'(busy[2]), 1);
        chk("h1_o", int'(o[2]), ((i / 2) % 2 == 0) ? 'h5 : 'h9);
      end else begin
        chk("h1_gap_ack", int'(ack[2]), 0);
        chk("h1_gap_busy", int'(busy[2]), 0);
      end
    end
    req[2] = 0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/out_nibble_arbiter.md
OUT_NIBBLE_ARBITER -- requirements
Module: out_nibble_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 2, number of cycles a granted nibble is held on O (legal range 1..15).
REQ-002 CLK  in  1  single clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 REQ  in  4  request, one bit per requester 0..3.
REQ-005 DIN  in  16  requester data, nibble i = DIN[4i+3:4i].
REQ-006 ACK  out  4  one-cycle grant acknowledge, one-hot or zero.
REQ-007 O  out  4  shared output nibble (drives core output pins O_0..O_3).
REQ-008 STB  out  1  one-cycle strobe marking a new nibble on O.
REQ-009 BUSY  out  1  high while in HOLD state.
REQ-010 GNT_ID  out  2  index of current/most recent winner.

Function
REQ-011 Two states: IDLE, HOLD; all outputs registered.
REQ-012 IDLE with REQ==0: remain IDLE; O, GNT_ID hold value; STB, ACK low.
REQ-013 IDLE with REQ!=0 at edge k: winner chosen round-robin, state -> HOLD; in cycle k+1: O = winner nibble sampled at edge k, GNT_ID = winner, ACK[winner]=1, STB=1, BUSY=1.
REQ-014 Round-robin order: LAST+1, LAST+2, LAST+3, LAST (mod 4), first set REQ bit wins; LAST <= winner on grant.
REQ-015 LAST resets to 3 so requester 0 has top priority after reset.
REQ-016 Hold counter loads HOLD_CYCLES-1 on grant, decrements each HOLD cycle; HOLD lasts exactly HOLD_CYCLES cycles, then state -> IDLE.
REQ-017 ACK and STB high only in first HOLD cycle; BUSY high for all HOLD cycles, low in IDLE.
REQ-018 No arbitration in HOLD; REQ changes during HOLD ignored; minimum grant-to-grant spacing HOLD_CYCLES+1 cycles.
REQ-019 O retains last granted nibble after HOLD until next grant.
REQ-020 Requester holds REQ and its DIN nibble stable until ACK, deasserts REQ on the edge ending the ACK cycle; a requester still requesting in next IDLE cycle is treated as a new request.
REQ-021 DIN of non-winning requesters never affects O.
REQ-022 Simultaneous requests: exactly one ACK bit per grant; losers remain pending and are served in round-robin order.
REQ-023 HOLD_CYCLES=1: HOLD is single cycle, ACK/STB/BUSY coincide, back to IDLE next edge.

Reset
REQ-024 RST high forces immediately (no clock needed): state IDLE, O=0, STB=0, ACK=0, BUSY=0, GNT_ID=0, LAST=3, counter=0.
REQ-025 RST asserted mid-HOLD aborts the hold; the in-progress grant is not repeated or resumed after reset.
REQ-026 First grant possible at first rising edge after RST deasserts.

Verification
REQ-027 Reset: RST=1 with REQ=4'hF -> all outputs 0, no ACK; release, next edge with REQ=4'hF -> ACK=4'b0001, GNT_ID=0, STB=1.
REQ-028 Single request: HOLD_CYCLES=2, REQ=4'b0100, DIN[11:8]=4'hA -> one cycle later O=4'hA, ACK=4'b0100, STB=1, BUSY=1 for 2 cycles, then BUSY=0, O stays 4'hA.
REQ-029 Fairness: REQ=4'hF held, each acked requester re-requests -> grant order 0,1,2,3,0, spacing 3 cycles with HOLD_CYCLES=2.
REQ-030 Ignore-in-HOLD: grant requester 1, raise REQ[0] during HOLD -> no ACK until IDLE; then ACK=4'b0001 (LAST=1, only 0 pending).
REQ-031 Mid-HOLD reset: HOLD_CYCLES=4, grant requester 2, assert RST in 2nd HOLD cycle -> O=0, BUSY=0 immediately; after release with REQ=4'b0100 -> fresh grant, ACK=4'b0100.
REQ-032 HOLD_CYCLES=1 with REQ=4'b1010 held -> ACK alternates 4'b0010, 4'b1000 every 2 cycles, STB each grant.
